// File: rtl/wishbone_rr_arbiter_pkg.sv
// Shared types for the wishbone round-robin arbiter.
package wishbone_rr_arbiter_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Slave-side request fields muxed from the owning master.
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  // Index width for n masters; at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first requester after 'last', wrapping.
module rr_priority_picker #(
  parameter int N    = 2,
  parameter int IDXW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [N-1:0]    gnt_oh,
  output logic [IDXW-1:0] gnt_idx
);

  logic            hi_hit;
  logic [IDXW-1:0] hi_idx;
  logic [IDXW-1:0] lo_idx;

  // Lowest requester above 'last' wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDXW'(i);
        if (i > int'(last)) begin
          hi_hit = 1'b1;
          hi_idx = IDXW'(i);
        end
      end
    end
    gnt_idx = hi_hit ? hi_idx : lo_idx;
    gnt_oh  = (|req) ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin wishbone arbiter: N masters share one slave, cycles are never split,
// and a watchdog errors the owner and reclaims the port if the slave stops acking.
import wishbone_rr_arbiter_pkg::*;

module wishbone_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [4*N_MASTERS-1:0]  m_sel_i,
  input  logic [32*N_MASTERS-1:0] m_adr_i,
  input  logic [32*N_MASTERS-1:0] m_dat_i,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic [31:0]             m_dat_o,
  output logic [N_MASTERS-1:0]    m_int_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [3:0]              s_sel_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  input  logic                    s_ack_i,
  input  logic [31:0]             s_dat_i,
  input  logic                    s_int_i,
  output logic [N_MASTERS-1:0]    grant_o,
  output logic                    timeout_o
);

  localparam int IDXW = idx_w(N_MASTERS);

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_MASTERS-1:0] pick_oh;
  logic [IDXW-1:0]      pick_idx;
  wb_req_t              req_a [N_MASTERS];

  // Unpack the flat per-master buses so the owner can be selected by index.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign req_a[i] = '{we:  m_we_i[i],
                        sel: m_sel_i[4*i +: 4],
                        adr: m_adr_i[32*i +: 32],
                        dat: m_dat_i[32*i +: 32]};
  end

  rr_priority_picker #(.N(N_MASTERS), .IDXW(IDXW)) u_picker (
    .req     (m_cyc_i),
    .last    (last_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Read data and interrupt are straight broadcasts from the slave.
  assign m_dat_o = s_dat_i;
  assign m_int_o = {N_MASTERS{s_int_i}};

  // Next-state, slave mux, ack/err routing and watchdog.
  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    cnt_d     = '0;
    grant_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pick_oh) begin
          gidx_d  = pick_idx;
          last_d  = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        grant_o[gidx_q] = 1'b1;
        s_cyc_o = m_cyc_i[gidx_q];
        s_stb_o = m_cyc_i[gidx_q] & m_stb_i[gidx_q];
        s_we_o  = req_a[gidx_q].we;
        s_sel_o = req_a[gidx_q].sel;
        s_adr_o = req_a[gidx_q].adr;
        s_dat_o = req_a[gidx_q].dat;
        m_ack_o[gidx_q] = s_ack_i;
        if (!m_cyc_i[gidx_q]) begin
          state_d = ST_IDLE;
        end else if (s_stb_o && !s_ack_i) begin
          // An ack on the threshold cycle takes the other branch, so ack beats the watchdog.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            m_err_o[gidx_q] = 1'b1;
            timeout_o       = 1'b1;
            state_d         = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Slave is cut off; wait for the errored master to end its cycle.
        grant_o[gidx_q] = 1'b1;
        if (!m_cyc_i[gidx_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; master 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gidx_q  <= '0;
      last_q  <= IDXW'(N_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, all outputs compared
// every cycle against a behavioural model of owner / drain / stall-count.
module tb_wishbone_rr_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;
  localparam int CW = 5;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [4*N-1:0]  m_sel_i;
  logic [32*N-1:0] m_adr_i, m_dat_i;
  logic [N-1:0]    m_ack_o, m_err_o, m_int_o, grant_o;
  logic [31:0]     m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_int_i, timeout_o;
  logic [3:0]      s_sel_o;

  wishbone_rr_arbiter #(.N_MASTERS(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .m_int_o(m_int_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .s_int_i(s_int_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus, whether it is being drained after a
  // watchdog error, how many stalled strobe cycles the current owner has
  // accumulated, and who was granted last.
  bit          valid = 1'b0;
  bit          have  = 1'b0;
  bit          drain = 1'b0;
  int          stall = 0;
  logic [IW-1:0] own  = '0;
  logic [IW-1:0] last = '0;
  bit          fire;
  bit          e_sstb;
  int          ack_mode = 1;   // 0 hung, 1 ack every strobe, 2 random ack, 3 rare ack

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave response, then compare every output with the model. Leaves time at negedge+2.
  task automatic settle();
    bit busy, e_scyc;
    #1;
    s_dat_i = $urandom;
    case (ack_mode)
      0:       s_ack_i = 1'b0;
      1:       s_ack_i = s_stb_o;
      2:       s_ack_i = ($urandom_range(0, 1) == 0);
      default: s_ack_i = s_stb_o && ($urandom_range(0, 23) == 0);
    endcase
    #1;
    busy   = have && !drain;
    e_scyc = busy && m_cyc_i[own];
    e_sstb = e_scyc && m_stb_i[own];
    // The watchdog fires on the TO-th consecutive un-acked strobe cycle.
    fire   = e_sstb && !s_ack_i && (stall + 1 >= TO);
    if (valid) begin
      chk("grant",   32'(grant_o),   have ? (32'd1 << own) : 32'd0);
      chk("s_cyc",   32'(s_cyc_o),   32'(e_scyc));
      chk("s_stb",   32'(s_stb_o),   32'(e_sstb));
      chk("s_we",    32'(s_we_o),    busy ? 32'(m_we_i[own]) : 32'd0);
      chk("s_sel",   32'(s_sel_o),   busy ? 32'(m_sel_i[4*own +: 4]) : 32'd0);
      chk("s_adr",   s_adr_o,        busy ? m_adr_i[32*own +: 32] : 32'd0);
      chk("s_dat",   s_dat_o,        busy ? m_dat_i[32*own +: 32] : 32'd0);
      chk("m_ack",   32'(m_ack_o),   (busy && s_ack_i) ? (32'd1 << own) : 32'd0);
      chk("m_err",   32'(m_err_o),   fire ? (32'd1 << own) : 32'd0);
      chk("timeout", 32'(timeout_o), 32'(fire));
      chk("m_dat",   m_dat_o,        s_dat_i);
      chk("m_int",   32'(m_int_o),   s_int_i ? 32'd3 : 32'd0);
    end
  endtask

  // Advance the model across the clock edge and return to the next negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      valid = 1'b1; have = 1'b0; drain = 1'b0; stall = 0; last = IW'(N - 1);
    end else if (valid) begin
      if (!have) begin
        for (int k = 1; k <= N; k++) begin
          logic [IW-1:0] cand;
          cand = IW'((int'(last) + k) % N);
          if (!have && m_cyc_i[cand]) begin
            have = 1'b1; own = cand; last = cand;
          end
        end
      end else if (!m_cyc_i[own]) begin
        have = 1'b0; drain = 1'b0; stall = 0;
      end else if (!drain) begin
        if (fire)                     begin drain = 1'b1; stall = 0; end
        else if (e_sstb && !s_ack_i)  stall++;
        else                          stall = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i[i] = cyc;
    m_stb_i[i] = stb;
    m_we_i[i]  = we;
    m_sel_i[4*i +: 4]   = 4'hF;
    m_adr_i[32*i +: 32] = adr;
    m_dat_i[32*i +: 32] = dat;
  endtask

  initial begin
    rst = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
    m_adr_i = '0; m_dat_i = '0; s_ack_i = 1'b0; s_dat_i = '0; s_int_i = 1'b0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    settle(); chk("rst_grant", 32'(grant_o), 32'd0); chk("rst_scyc", 32'(s_cyc_o), 32'd0); tick();

    // Single master write: s_cyc_o follows cyc by one cycle.
    set_m(0, 1, 1, 1, 32'h0, 32'h1234_5678);
    settle(); chk("t1_lat0", 32'(s_cyc_o), 32'd0); tick();
    settle(); chk("t1_cyc", 32'(s_cyc_o), 32'd1); chk("t1_dat", s_dat_o, 32'h1234_5678);
    chk("t1_ack", 32'(m_ack_o), 32'd1); tick();
    set_m(0, 0, 0, 0, 0, 0);
    step(); step();

    // Contention: after m0-only service the next tie goes to m1.
    set_m(0, 1, 1, 0, 32'h40, 32'h0); set_m(1, 1, 1, 0, 32'h80, 32'h0);
    step();
    settle(); chk("t2_tie_m1", 32'(grant_o), 32'd2); tick();
    set_m(1, 0, 0, 0, 0, 0);
    settle(); tick();
    settle(); chk("t2_dead", 32'(grant_o), 32'd0); tick();
    settle(); chk("t2_m0", 32'(grant_o), 32'd1); tick();
    set_m(0, 0, 0, 0, 0, 0);
    step(); step();

    // Reset, then tie: m0 first, m1 only after m0 releases plus a dead cycle;
    // m0 holds its cycle over three acked beats while m1 waits.
    rst = 1'b1; step(); rst = 1'b0;
    set_m(0, 1, 1, 1, 32'h10, 32'hA5A5_0001); set_m(1, 1, 1, 0, 32'h20, 32'h0);
    step();
    for (int b = 0; b < 3; b++) begin
      m_dat_i[31:0] = 32'hA5A5_0001 + b;
      settle(); chk("t3_hold", 32'(grant_o), 32'd1); chk("t3_ack", 32'(m_ack_o), 32'd1); tick();
    end
    set_m(0, 0, 0, 0, 0, 0);
    step();
    settle(); chk("t2_gap", 32'(grant_o), 32'd0); tick();
    settle(); chk("t2_m1", 32'(grant_o), 32'd2); tick();
    set_m(1, 0, 0, 0, 0, 0);
    step(); step();

    // Hung slave: error on the 16th stalled strobe, then drain, then m1 is served.
    ack_mode = 0;
    set_m(0, 1, 1, 0, 32'h100, 32'h0); set_m(1, 1, 1, 0, 32'h200, 32'h0);
    step();
    for (int c = 0; c < TO; c++) begin
      settle();
      chk("t4_to", 32'(timeout_o), (c == TO - 1) ? 32'd1 : 32'd0);
      chk("t4_err", 32'(m_err_o), (c == TO - 1) ? 32'd1 : 32'd0);
      tick();
    end
    settle(); chk("t4_drain_cyc", 32'(s_cyc_o), 32'd0); chk("t4_drain_g", 32'(grant_o), 32'd1);
    chk("t4_pulse", 32'(timeout_o), 32'd0); tick();
    set_m(0, 0, 0, 0, 0, 0); ack_mode = 1;
    step(); step();
    settle(); chk("t4_m1", 32'(grant_o), 32'd2); chk("t4_m1ack", 32'(m_ack_o), 32'd2); tick();

    // Reset while busy: bus freed with no ack/err, then a tie goes to m0.
    set_m(0, 1, 1, 0, 32'h300, 32'h0);
    rst = 1'b1; step(); rst = 1'b0;
    settle(); chk("t5_grant", 32'(grant_o), 32'd0); chk("t5_cyc", 32'(s_cyc_o), 32'd0);
    chk("t5_ack", 32'(m_ack_o), 32'd0); chk("t5_err", 32'(m_err_o), 32'd0); tick();
    settle(); chk("t5_m0", 32'(grant_o), 32'd1); tick();

    // Interrupt is broadcast regardless of grant.
    s_int_i = 1'b1;
    settle(); chk("t6_int", 32'(m_int_o), 32'd3); tick();
    s_int_i = 1'b0;
    set_m(0, 0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0, 0);
    step(); step();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) ack_mode = $urandom_range(0, 3);
      rst = ($urandom_range(0, 299) == 0);
      s_int_i = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (!m_cyc_i[i]) m_cyc_i[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 39) == 0) m_cyc_i[i] = 1'b0;
        m_stb_i[i] = m_cyc_i[i] && (m_stb_i[i] ? ($urandom_range(0, 15) != 0)
                                               : ($urandom_range(0, 1) == 0));
        m_we_i[i] = $urandom_range(0, 1) == 1;
        m_sel_i[4*i +: 4]   = 4'($urandom);
        m_adr_i[32*i +: 32] = $urandom;
        m_dat_i[32*i +: 32] = $urandom;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
